regfile_access_sequencer: RTL and testbench

- Sequences all traffic into the single-port register_file memory (clka, wea[3:0], addra[31:0], dina[31:0], douta[31:0]) for the KGP-RISC core.
- Turns one decode-stage request (read rs, read rt, optional write rd) into serial memory cycles.
- Zero-fills the file after reset, enforces the r0 rules and returns both operands through a valid/ready handshake.

---
 rtl/regfile_access_sequencer_pkg.sv | 25 ++
 rtl/regfile_rd_tag_pipe.sv | 48 ++++
 rtl/regfile_access_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_regfile_access_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_sequencer_pkg.sv
// rtl/regfile_access_sequencer_pkg.sv - shared types and constants for the register-file access sequencer
package regfile_access_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD_RS,
      ST_RD_RT,
      ST_DRAIN,
      ST_WRITE,
      ST_RESP
   } state_e;

   // Identifies which operand an in-flight memory read belongs to.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_RS   = 2'd1,
      TAG_RT   = 2'd2
   } tag_e;

   localparam int                    DEF_WE_W = 4;
   localparam logic [DEF_WE_W-1:0]   WE_ALL   = {DEF_WE_W{1'b1}};
   localparam int                    REG_ZERO = 0;

endpackage

// File: rtl/regfile_rd_tag_pipe.sv
// rtl/regfile_rd_tag_pipe.sv - RD_LAT-deep tag shift register tracking reads in flight to the register file
module regfile_rd_tag_pipe
   import regfile_access_sequencer_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clka,
   input  logic rst_n,
   input  tag_e push_tag_i,
   output tag_e pop_tag_o,
   output logic empty_o
);

   tag_e stages_q [RD_LAT];
   tag_e stages_d [RD_LAT];

   always_comb begin
      stages_d[0] = push_tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
         stages_d[i] = stages_q[i-1];
      end
   end

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stages_q[i] <= TAG_NONE;
         end
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            stages_q[i] <= stages_d[i];
         end
      end
   end

   assign pop_tag_o = stages_q[RD_LAT-1];

   // High when nothing will remain in flight once this cycle's tag has popped.
   always_comb begin
      empty_o = (push_tag_i == TAG_NONE);
      for (int i = 0; i < RD_LAT - 1; i++) begin
         if (stages_q[i] != TAG_NONE) begin
            empty_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_access_sequencer.sv
// rtl/regfile_access_sequencer.sv - serialises decode-stage rs/rt reads and rd write onto the single-port register file
module regfile_access_sequencer
   import regfile_access_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WE_W     = 4,
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int RD_LAT   = 1
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [IDX_W-1:0]  req_rs,
   input  logic [IDX_W-1:0]  req_rt,
   input  logic              req_wr_en,
   input  logic [IDX_W-1:0]  req_rd,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              init_done,
   output logic [WE_W-1:0]   mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dina,
   input  logic [DATA_W-1:0] mem_douta
);

   localparam logic [WE_W-1:0]  WE_ONES   = {WE_W{WE_ALL[0]}};
   localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(REG_ZERO);
   localparam logic [IDX_W:0]   INIT_LAST = (IDX_W+1)'(NUM_REGS);

   state_e              state_q, state_d;
   logic [IDX_W:0]      init_idx_q, init_idx_d;
   logic                init_done_q, init_done_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   rs_data_q, rs_data_d;
   logic [DATA_W-1:0]   rt_data_q, rt_data_d;
   logic [WE_W-1:0]     mem_wea_q, mem_wea_d;
   logic [ADDR_W-1:0]   mem_addra_q, mem_addra_d;
   logic [DATA_W-1:0]   mem_dina_q, mem_dina_d;
   logic [IDX_W-1:0]    rs_q, rs_d;
   logic [IDX_W-1:0]    rt_q, rt_d;
   logic [IDX_W-1:0]    rd_q, rd_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   tag_e                push_tag;
   tag_e                pop_tag;
   logic                pipe_empty;

   regfile_rd_tag_pipe #(
      .RD_LAT(RD_LAT)
   ) u_tag_pipe (
      .clka      (clka),
      .rst_n     (rst_n),
      .push_tag_i(push_tag),
      .pop_tag_o (pop_tag),
      .empty_o   (pipe_empty)
   );

   // Registered outputs are computed for the state being entered, so each
   // memory cycle is presented while state_q names that cycle.
   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      init_done_d  = init_done_q;
      rs_data_d    = rs_data_q;
      rt_data_d    = rt_data_q;
      mem_wea_d    = '0;
      mem_addra_d  = mem_addra_q;
      mem_dina_d   = mem_dina_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      rd_d         = rd_q;
      wr_en_d      = wr_en_q;
      wdata_d      = wdata_q;
      push_tag     = TAG_NONE;

      case (state_q)
         ST_INIT: begin
            if (init_idx_q == INIT_LAST) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               mem_wea_d   = WE_ONES;
               mem_addra_d = ADDR_W'(init_idx_q);
               mem_dina_d  = '0;
               init_idx_d  = init_idx_q + (IDX_W+1)'(1);
            end
         end
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               rs_d        = req_rs;
               rt_d        = req_rt;
               rd_d        = req_rd;
               wr_en_d     = req_wr_en;
               wdata_d     = req_wdata;
               mem_addra_d = ADDR_W'(req_rs);
               state_d     = ST_RD_RS;
            end
         end
         ST_RD_RS: begin
            push_tag    = TAG_RS;
            mem_addra_d = ADDR_W'(rt_q);
            state_d     = ST_RD_RT;
         end
         ST_RD_RT: begin
            push_tag = TAG_RT;
            state_d  = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               if (wr_en_q) begin
                  mem_addra_d = ADDR_W'(rd_q);
                  mem_dina_d  = wdata_q;
                  mem_wea_d   = (rd_q == IDX_ZERO) ? '0 : WE_ONES;
                  state_d     = ST_WRITE;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WRITE: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Read data lands on the edge its tag leaves the pipe; r0 always reads zero.
      if (pop_tag == TAG_RS) begin
         rs_data_d = (rs_q == IDX_ZERO) ? '0 : mem_douta;
      end
      if (pop_tag == TAG_RT) begin
         rt_data_d = (rt_q == IDX_ZERO) ? '0 : mem_douta;
      end

      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         init_done_q  <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         mem_wea_q    <= '0;
         mem_addra_q  <= '0;
         mem_dina_q   <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         wr_en_q      <= 1'b0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         init_done_q  <= init_done_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         rs_data_q    <= rs_data_d;
         rt_data_q    <= rt_data_d;
         mem_wea_q    <= mem_wea_d;
         mem_addra_q  <= mem_addra_d;
         mem_dina_q   <= mem_dina_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         wr_en_q      <= wr_en_d;
         wdata_q      <= wdata_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign rs_data    = rs_data_q;
   assign rt_data    = rt_data_q;
   assign init_done  = init_done_q;
   assign mem_wea    = mem_wea_q;
   assign mem_addra  = mem_addra_q;
   assign mem_dina   = mem_dina_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb/tb_regfile_access_sequencer.sv - self-checking bench for regfile_access_sequencer with a register_file model
module tb_regfile_access_sequencer;

   typedef struct {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        wr_en;
      logic [31:0] wdata;
      logic [31:0] exp_rs;
      logic [31:0] exp_rt;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] rs;
      logic [31:0] rt;
   } resp_t;

   logic        clka = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic        req_wr_en;
   logic [4:0]  req_rd;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        init_done;
   logic [3:0]  mem_wea;
   logic [31:0] mem_addra;
   logic [31:0] mem_dina;
   logic [31:0] mem_douta;

   int          checks = 0;
   int          errors = 0;
   resp_t       sb_q[$];
   vec_t        vecs[10];
   logic [31:0] regmem [32];

   always #5 clka = ~clka;

   regfile_access_sequencer dut (
      .clka      (clka),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_rt    (req_rt),
      .req_wr_en (req_wr_en),
      .req_rd    (req_rd),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .init_done (init_done),
      .mem_wea   (mem_wea),
      .mem_addra (mem_addra),
      .mem_dina  (mem_dina),
      .mem_douta (mem_douta)
   );

   // Single-port memory, one-cycle read; scrambled while reset is low so zero-fill is observable.
   always @(posedge clka) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regmem[i] <= 32'hA5A5_0000 | 32'(i);
      end else if (mem_wea != 4'h0) begin
         regmem[mem_addra[4:0]] <= mem_dina;
      end
      mem_douta <= regmem[mem_addra[4:0]];
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clka) begin
      if (rst_n && resp_valid && resp_ready) begin
         resp_t exp_r;
         chk("sb_has_entry", 128'(sb_q.size() != 0), 128'(1));
         if (sb_q.size() != 0) begin
            exp_r = sb_q.pop_front();
            chk("sb_rs_data", 128'(rs_data), 128'(exp_r.rs));
            chk("sb_rt_data", 128'(rt_data), 128'(exp_r.rt));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, 128'({req_ready, resp_valid, init_done, mem_wea}), 128'(0));
      chk({tag, "_mem_bus"}, 128'({mem_addra, mem_dina}), 128'(0));
      chk({tag, "_data"}, 128'({rs_data, rt_data}), 128'(0));
   endtask

   task automatic check_init(input string tag);
      int cyc = 0;
      int bad = 0;
      while (cyc < 64) begin
         @(posedge clka); #1;
         if (init_done) break;
         if (mem_wea !== 4'hF || mem_addra !== 32'(cyc) || mem_dina !== 32'h0) bad++;
         cyc++;
      end
      chk({tag, "_write_cycles"}, 128'(cyc), 128'(32));
      chk({tag, "_write_pattern"}, 128'(bad), 128'(0));
      chk({tag, "_idle_after"}, 128'({init_done, req_ready, resp_valid, mem_wea}), 128'({1'b1, 1'b1, 1'b0, 4'h0}));
   endtask

   task automatic do_request(input vec_t v, input string name);
      int          n;
      int          waitc = 0;
      int          writes = 0;
      logic [3:0]  ww = '0;
      logic [31:0] wa = '0;
      logic [31:0] wd = '0;
      while (!req_ready && waitc < 100) begin
         @(posedge clka); #1;
         waitc++;
      end
      chk({name, "_ready"}, 128'(req_ready), 128'(1));
      req_rs    = v.rs;
      req_rt    = v.rt;
      req_rd    = v.rd;
      req_wr_en = v.wr_en;
      req_wdata = v.wdata;
      req_valid = 1'b1;
      sb_q.push_back('{rs: v.exp_rs, rt: v.exp_rt});
      @(posedge clka); #1;
      req_valid = 1'b0;
      chk({name, "_busy"}, 128'(req_ready), 128'(0));
      n = 1;
      while (!resp_valid && n < 20) begin
         if (mem_wea != 4'h0) begin
            writes++;
            ww = mem_wea;
            wa = mem_addra;
            wd = mem_dina;
         end
         @(posedge clka); #1;
         n++;
      end
      chk({name, "_latency"}, 128'(n), 128'(v.exp_lat));
      chk({name, "_write_cycles"}, 128'(writes), 128'((v.wr_en && v.rd != 5'd0) ? 1 : 0));
      if (writes == 1) chk({name, "_write_bus"}, 128'({ww, wa, wd}), 128'({4'hF, 27'b0, v.rd, v.wdata}));
      @(posedge clka); #1;
      chk({name, "_to_idle"}, 128'({resp_valid, req_ready}), 128'(2'b01));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          stable_errs;
      logic [31:0] held_rs, held_rt;

      vecs[0] = '{5'd0,  5'd0,  5'd4,  1'b1, 32'd123,        32'd0,          32'd0,          5};
      vecs[1] = '{5'd4,  5'd2,  5'd0,  1'b0, 32'd0,          32'd123,        32'd0,          4};
      vecs[2] = '{5'd4,  5'd4,  5'd4,  1'b1, 32'hFFFF_FFFF,  32'd123,        32'd123,        5};
      vecs[3] = '{5'd4,  5'd0,  5'd0,  1'b0, 32'd0,          32'hFFFF_FFFF,  32'd0,          4};
      vecs[4] = '{5'd7,  5'd4,  5'd0,  1'b1, 32'hDEAD_BEEF,  32'd0,          32'hFFFF_FFFF,  5};
      vecs[5] = '{5'd0,  5'd7,  5'd0,  1'b0, 32'd0,          32'd0,          32'd0,          4};
      vecs[6] = '{5'd31, 5'd4,  5'd31, 1'b1, 32'h8000_0001,  32'd0,          32'hFFFF_FFFF,  5};
      vecs[7] = '{5'd31, 5'd31, 5'd0,  1'b0, 32'd0,          32'h8000_0001,  32'h8000_0001,  4};
      vecs[8] = '{5'd1,  5'd31, 5'd1,  1'b1, 32'h1234_5678,  32'd0,          32'h8000_0001,  5};
      vecs[9] = '{5'd1,  5'd0,  5'd0,  1'b0, 32'd0,          32'h1234_5678,  32'd0,          4};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_rs     = '0;
      req_rt     = '0;
      req_rd     = '0;
      req_wr_en  = 1'b0;
      req_wdata  = '0;
      resp_ready = 1'b1;

      repeat (3) @(posedge clka);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      check_init("init");

      for (int i = 0; i < 10; i++) begin
         do_request(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-pressure: response must hold while a stray request is ignored.
      resp_ready = 1'b0;
      req_rs     = 5'd1;
      req_rt     = 5'd4;
      req_wr_en  = 1'b0;
      req_valid  = 1'b1;
      sb_q.push_back('{rs: 32'h1234_5678, rt: 32'hFFFF_FFFF});
      @(posedge clka); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clka); #1;
         n++;
      end
      chk("hold_resp_seen", 128'(resp_valid), 128'(1));
      held_rs   = rs_data;
      held_rt   = rt_data;
      req_rs    = 5'd2;
      req_rt    = 5'd2;
      req_rd    = 5'd2;
      req_wr_en = 1'b1;
      req_wdata = 32'hBAD0_BAD0;
      req_valid = 1'b1;
      stable_errs = 0;
      repeat (5) begin
         @(posedge clka); #1;
         if (!resp_valid || rs_data !== held_rs || rt_data !== held_rt || req_ready) stable_errs++;
      end
      chk("hold_stable", 128'(stable_errs), 128'(0));
      req_valid  = 1'b0;
      req_wr_en  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clka); #1;
      chk("hold_release", 128'({resp_valid, req_ready}), 128'(2'b01));
      do_request('{5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4}, "ignored_req");

      // Abort mid-request in RD_RT; the lost write must never reach memory.
      req_rs    = 5'd4;
      req_rt    = 5'd31;
      req_rd    = 5'd5;
      req_wr_en = 1'b1;
      req_wdata = 32'd55;
      req_valid = 1'b1;
      @(posedge clka); #1;
      req_valid = 1'b0;
      req_wr_en = 1'b0;
      @(posedge clka); #1;
      rst_n = 1'b0;
      @(posedge clka); #1;
      check_reset_outputs("abort");
      @(posedge clka); #1;
      rst_n = 1'b1;
      check_init("reinit");
      for (int i = 0; i < 16; i++) begin
         do_request('{5'(i), 5'(31 - i), 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4}, $sformatf("zero%0d", i));
      end

      @(negedge clka);
      chk("sb_drained", 128'(sb_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
